segmem_arb_ctrl: RTL and testbench

SEGMEM_ARB_CTRL -- requirements
Module: segmem_arb_ctrl

---
 rtl/tcam_pkg.sv | 19 +
 rtl/segmem_arb_ctrl_if.sv | 36 +++
 rtl/ffxkclkx.sv | 25 ++
 rtl/seg_slot_merge.sv | 16 +
 rtl/segmem_arb_ctrl.sv | 127 ++++++++++++
 tb/tb_segmem_arb_ctrl.sv | 196 +++++++++++++++++++
 6 files changed

// File: rtl/tcam_pkg.sv
// rtl/tcam_pkg.sv - shared widths, FSM encoding and slot helper for the segment-memory arbiter
package tcam_pkg;
    localparam int AWID       = 8;
    localparam int SEGWID     = 10;
    localparam int MASKWID    = 13;
    localparam int VTWID      = SEGWID * MASKWID;
    localparam int SLOTW      = 4;
    localparam int STARVE_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_UPD_WAIT = 2'd1,
        ST_UPD_WR   = 2'd2
    } state_e;

    function automatic logic slot_valid(input logic [SLOTW-1:0] slot);
        return slot < SLOTW'(MASKWID);
    endfunction
endpackage

// File: rtl/segmem_arb_ctrl_if.sv
// rtl/segmem_arb_ctrl_if.sv - search/update request and memory port bundle
interface segmem_arb_ctrl_if;
    import tcam_pkg::*;

    logic              i_Srch_Valid;
    logic [AWID-1:0]   i_Srch_Addr;
    logic              o_Srch_Ready;
    logic              i_Upd_Valid;
    logic [AWID-1:0]   i_Upd_Addr;
    logic [SLOTW-1:0]  i_Upd_Slot;
    logic [SEGWID-1:0] i_Upd_Segment;
    logic              o_Upd_Ready;
    logic              o_Upd_Done;
    logic              o_Upd_Err;
    logic              o_Mem_En;
    logic              o_Mem_We;
    logic [AWID-1:0]   o_Mem_Addr;
    logic [VTWID-1:0]  o_Mem_Wdata;
    logic [VTWID-1:0]  i_Mem_Rdata;
    logic [VTWID-1:0]  o_Srch_Vect;
    logic              o_Srch_Vect_Valid;

    modport slave (
        input  i_Srch_Valid, i_Srch_Addr, i_Upd_Valid, i_Upd_Addr, i_Upd_Slot,
               i_Upd_Segment, i_Mem_Rdata,
        output o_Srch_Ready, o_Upd_Ready, o_Upd_Done, o_Upd_Err, o_Mem_En, o_Mem_We,
               o_Mem_Addr, o_Mem_Wdata, o_Srch_Vect, o_Srch_Vect_Valid
    );

    modport master (
        output i_Srch_Valid, i_Srch_Addr, i_Upd_Valid, i_Upd_Addr, i_Upd_Slot,
               i_Upd_Segment, i_Mem_Rdata,
        input  o_Srch_Ready, o_Upd_Ready, o_Upd_Done, o_Upd_Err, o_Mem_En, o_Mem_We,
               o_Mem_Addr, o_Mem_Wdata, o_Srch_Vect, o_Srch_Vect_Valid
    );
endinterface

// File: rtl/ffxkclkx.sv
// rtl/ffxkclkx.sv - generic k-stage pipeline register with every stage exposed
module ffxkclkx #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       d_i,
    output logic [DEPTH*WIDTH-1:0] pipe_o
);
    logic [DEPTH*WIDTH-1:0] pipe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[WIDTH-1:0] <= d_i;
            for (int k = 1; k < DEPTH; k++) begin
                pipe_q[k*WIDTH +: WIDTH] <= pipe_q[(k-1)*WIDTH +: WIDTH];
            end
        end
    end

    assign pipe_o = pipe_q;
endmodule

// File: rtl/seg_slot_merge.sv
// rtl/seg_slot_merge.sv - replaces one segment slot of a vector; out-of-range slots pass through
module seg_slot_merge import tcam_pkg::*; (
    input  logic [VTWID-1:0]  vect_i,
    input  logic [SLOTW-1:0]  slot_i,
    input  logic [SEGWID-1:0] seg_i,
    output logic [VTWID-1:0]  vect_o
);
    always_comb begin
        vect_o = vect_i;
        for (int k = 0; k < MASKWID; k++) begin
            if (slot_i == SLOTW'(k)) begin
                vect_o[k*SEGWID +: SEGWID] = seg_i;
            end
        end
    end
endmodule

// File: rtl/segmem_arb_ctrl.sv
// rtl/segmem_arb_ctrl.sv - arbitrates single-cycle searches against read-modify-write segment updates
// Searches win unless an update has waited STARVE consecutive search grants.
module segmem_arb_ctrl import tcam_pkg::*; #(
    parameter int STARVE = STARVE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    segmem_arb_ctrl_if.slave bus
);
    localparam int              CNTW       = $clog2(STARVE + 1);
    localparam logic [CNTW-1:0] STARVE_MAX = CNTW'(STARVE);

    state_e            state_q, state_d;
    logic [CNTW-1:0]   starve_q, starve_d;
    logic [AWID-1:0]   addr_q;
    logic [AWID-1:0]   upd_addr_q;
    logic [SLOTW-1:0]  slot_q;
    logic [SEGWID-1:0] seg_q;
    logic [VTWID-1:0]  merged_q, merged_d;
    logic [VTWID-1:0]  vect_q;
    logic              err_q;
    logic              srch_gnt, upd_gnt, upd_ok, upd_done;
    logic              mem_en, mem_we;
    logic [AWID-1:0]   mem_addr;
    logic [1:0]        srch_pipe;

    seg_slot_merge u_merge (
        .vect_i (bus.i_Mem_Rdata),
        .slot_i (slot_q),
        .seg_i  (seg_q),
        .vect_o (merged_d)
    );

    // stage 0 marks read data arriving, stage 1 is the vector-valid strobe
    ffxkclkx #(.WIDTH(1), .DEPTH(2)) u_srch_dly (
        .clk    (clk),
        .rst    (rst),
        .d_i    (srch_gnt),
        .pipe_o (srch_pipe)
    );

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        srch_gnt = 1'b0;
        upd_gnt  = 1'b0;
        upd_done = 1'b0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = addr_q;
        upd_ok   = slot_valid(bus.i_Upd_Slot);
        // grants are gated so every output reads 0 while reset is held
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_Srch_Valid && (!bus.i_Upd_Valid || starve_q < STARVE_MAX)) begin
                        srch_gnt = 1'b1;
                        mem_en   = 1'b1;
                        mem_addr = bus.i_Srch_Addr;
                    end else if (bus.i_Upd_Valid) begin
                        upd_gnt = 1'b1;
                        if (upd_ok) begin
                            mem_en   = 1'b1;
                            mem_addr = bus.i_Upd_Addr;
                            state_d  = ST_UPD_WAIT;
                        end
                    end
                end
                ST_UPD_WAIT: state_d = ST_UPD_WR;
                ST_UPD_WR: begin
                    mem_en   = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = upd_addr_q;
                    upd_done = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
            if (!bus.i_Upd_Valid || upd_gnt) begin
                starve_d = '0;
            end else if (srch_gnt && starve_q < STARVE_MAX) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            starve_q   <= '0;
            addr_q     <= '0;
            upd_addr_q <= '0;
            slot_q     <= '0;
            seg_q      <= '0;
            merged_q   <= '0;
            vect_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            addr_q   <= mem_addr;
            err_q    <= upd_gnt && !upd_ok;
            if (upd_gnt) begin
                upd_addr_q <= bus.i_Upd_Addr;
                slot_q     <= bus.i_Upd_Slot;
                seg_q      <= bus.i_Upd_Segment;
            end
            if (state_q == ST_UPD_WAIT) begin
                merged_q <= merged_d;
            end
            if (srch_pipe[0]) begin
                vect_q <= bus.i_Mem_Rdata;
            end
        end
    end

    assign bus.o_Srch_Ready      = srch_gnt;
    assign bus.o_Upd_Ready       = upd_gnt;
    assign bus.o_Upd_Done        = upd_done;
    assign bus.o_Upd_Err         = err_q;
    assign bus.o_Mem_En          = mem_en;
    assign bus.o_Mem_We          = mem_we;
    assign bus.o_Mem_Addr        = mem_addr;
    assign bus.o_Mem_Wdata       = merged_q;
    assign bus.o_Srch_Vect       = vect_q;
    assign bus.o_Srch_Vect_Valid = srch_pipe[1];
endmodule

// File: tb/tb_segmem_arb_ctrl.sv
// tb/tb_segmem_arb_ctrl.sv - directed bench for segmem_arb_ctrl against a behavioural memory
module tb_segmem_arb_ctrl;
    import tcam_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    int               checks = 0;
    int               errors = 0;
    int               we_cnt = 0;
    logic [VTWID-1:0] mem [256];
    logic [VTWID-1:0] rdata_q = '0;
    logic [VTWID-1:0] pat_p, pat_q, exp_v;
    string            seq;

    segmem_arb_ctrl_if bus ();

    segmem_arb_ctrl #(.STARVE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.i_Mem_Rdata = rdata_q;

    always @(posedge clk) begin
        if (bus.o_Mem_We) we_cnt++;
        if (bus.o_Mem_En) begin
            if (bus.o_Mem_We) mem[bus.o_Mem_Addr] <= bus.o_Mem_Wdata;
            else              rdata_q <= mem[bus.o_Mem_Addr];
        end
    end

    task automatic chk(input string tag, input logic [VTWID-1:0] obs, input logic [VTWID-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic [7:0] sa, input logic uv,
                         input logic [7:0] ua, input logic [3:0] us, input logic [9:0] useg);
        bus.i_Srch_Valid  = sv;
        bus.i_Srch_Addr   = sa;
        bus.i_Upd_Valid   = uv;
        bus.i_Upd_Addr    = ua;
        bus.i_Upd_Slot    = us;
        bus.i_Upd_Segment = useg;
    endtask

    initial begin
        rst = 1'b1;
        drive(1, 8'h05, 1, 8'h33, 4'd0, 10'h000);
        for (int i = 0; i < 256; i++) mem[i] = '0;
        pat_p = {2'b10, 128'hDEADBEEF_0123_4567_89AB_CDEF_F00D_CAFE};
        pat_q = {13{10'h155}};
        mem[8'h05] = pat_p;
        mem[8'h20] = pat_q;

        // reset state with both requests pending
        @(negedge clk); #1;
        chk("rst_srch_ready", bus.o_Srch_Ready, 0);
        chk("rst_upd_ready", bus.o_Upd_Ready, 0);
        chk("rst_mem_en", bus.o_Mem_En, 0);
        chk("rst_mem_we", bus.o_Mem_We, 0);
        chk("rst_mem_addr", bus.o_Mem_Addr, 0);
        chk("rst_wdata", bus.o_Mem_Wdata, 0);
        chk("rst_vect", bus.o_Srch_Vect, 0);
        chk("rst_vvalid", bus.o_Srch_Vect_Valid, 0);
        chk("rst_done", bus.o_Upd_Done, 0);
        chk("rst_err", bus.o_Upd_Err, 0);

        // reset exit with both valids: search wins; single search of 0x05
        @(negedge clk); rst = 1'b0; #1;
        chk("exit_srch_ready", bus.o_Srch_Ready, 1);
        chk("exit_upd_ready", bus.o_Upd_Ready, 0);
        chk("srch_mem_en", bus.o_Mem_En, 1);
        chk("srch_mem_we", bus.o_Mem_We, 0);
        chk("srch_mem_addr", bus.o_Mem_Addr, 8'h05);
        @(negedge clk); drive(0, 8'h05, 0, 8'h00, 4'd0, 10'h000); #1;
        chk("srch_vvalid_c1", bus.o_Srch_Vect_Valid, 0);
        chk("idle_mem_en", bus.o_Mem_En, 0);
        chk("idle_addr_hold", bus.o_Mem_Addr, 8'h05);
        @(negedge clk); #1;
        chk("srch_vvalid_c2", bus.o_Srch_Vect_Valid, 1);
        chk("srch_vect_p", bus.o_Srch_Vect, pat_p);
        @(negedge clk); #1;
        chk("srch_vvalid_c3", bus.o_Srch_Vect_Valid, 0);
        chk("srch_vect_hold", bus.o_Srch_Vect, pat_p);

        // update 0x10 slot 3 seg 0x1AB over zeros, then search 0x10 right after UPD_WR
        @(negedge clk); drive(0, 8'h00, 1, 8'h10, 4'd3, 10'h1AB); #1;
        chk("upd_ready", bus.o_Upd_Ready, 1);
        chk("upd_srch_ready", bus.o_Srch_Ready, 0);
        chk("upd_rd_en", bus.o_Mem_En, 1);
        chk("upd_rd_we", bus.o_Mem_We, 0);
        chk("upd_rd_addr", bus.o_Mem_Addr, 8'h10);
        @(negedge clk); drive(1, 8'h10, 0, 8'h10, 4'd3, 10'h1AB); #1;
        chk("wait_srch_ready", bus.o_Srch_Ready, 0);
        chk("wait_mem_en", bus.o_Mem_En, 0);
        chk("wait_done", bus.o_Upd_Done, 0);
        @(negedge clk); #1;
        chk("wr_srch_ready", bus.o_Srch_Ready, 0);
        chk("wr_mem_en", bus.o_Mem_En, 1);
        chk("wr_mem_we", bus.o_Mem_We, 1);
        chk("wr_addr", bus.o_Mem_Addr, 8'h10);
        chk("wr_wdata", bus.o_Mem_Wdata, 130'h6AC0000000);
        chk("wr_done", bus.o_Upd_Done, 1);
        @(negedge clk); #1;
        chk("post_srch_ready", bus.o_Srch_Ready, 1);
        chk("post_srch_addr", bus.o_Mem_Addr, 8'h10);
        chk("post_done", bus.o_Upd_Done, 0);
        chk("write_count_1", we_cnt, 1);
        @(negedge clk); drive(0, 8'h00, 0, 8'h00, 4'd0, 10'h000); #1;
        @(negedge clk); #1;
        chk("post_vvalid", bus.o_Srch_Vect_Valid, 1);
        chk("post_vect_new", bus.o_Srch_Vect, 130'h6AC0000000);

        // search one cycle before update to same address: old then merged vector
        exp_v = {10'h0F0, {12{10'h155}}};
        @(negedge clk); drive(1, 8'h20, 1, 8'h20, 4'd12, 10'h0F0); #1;
        chk("race_srch_first", bus.o_Srch_Ready, 1);
        chk("race_upd_blocked", bus.o_Upd_Ready, 0);
        @(negedge clk); drive(0, 8'h20, 1, 8'h20, 4'd12, 10'h0F0); #1;
        chk("race_upd_ready", bus.o_Upd_Ready, 1);
        chk("race_upd_addr", bus.o_Mem_Addr, 8'h20);
        @(negedge clk); drive(1, 8'h20, 0, 8'h20, 4'd12, 10'h0F0); #1;
        chk("race_old_vvalid", bus.o_Srch_Vect_Valid, 1);
        chk("race_old_vect", bus.o_Srch_Vect, pat_q);
        @(negedge clk); #1;
        chk("race_wr_we", bus.o_Mem_We, 1);
        chk("race_wr_wdata", bus.o_Mem_Wdata, exp_v);
        @(negedge clk); #1;
        chk("race_resrch", bus.o_Srch_Ready, 1);
        @(negedge clk); drive(0, 8'h00, 0, 8'h00, 4'd0, 10'h000); #1;
        @(negedge clk); #1;
        chk("race_new_vvalid", bus.o_Srch_Vect_Valid, 1);
        chk("race_new_vect", bus.o_Srch_Vect, exp_v);

        // out-of-range slot 13: accepted, error pulse, no memory access
        @(negedge clk); drive(0, 8'h00, 1, 8'h05, 4'd13, 10'h2AA); #1;
        chk("bad_upd_ready", bus.o_Upd_Ready, 1);
        chk("bad_mem_en", bus.o_Mem_En, 0);
        @(negedge clk); drive(1, 8'h05, 0, 8'h00, 4'd0, 10'h000); #1;
        chk("bad_err_pulse", bus.o_Upd_Err, 1);
        chk("bad_still_idle", bus.o_Srch_Ready, 1);
        chk("bad_done", bus.o_Upd_Done, 0);
        @(negedge clk); drive(0, 8'h00, 0, 8'h00, 4'd0, 10'h000); #1;
        chk("bad_err_clear", bus.o_Upd_Err, 0);
        @(negedge clk); #1;
        chk("bad_mem_unchanged", bus.o_Srch_Vect, pat_p);
        chk("write_count_2", we_cnt, 2);

        // both valids held: SSSSU then two update cycles, repeating
        seq = "SSSSU--";
        for (int i = 0; i < 21; i++) begin
            @(negedge clk); drive(1, 8'h41, 1, 8'h40, 4'd0, 10'h001); #1;
            chk("starve_srch", bus.o_Srch_Ready, seq[i % 7] == "S");
            chk("starve_upd", bus.o_Upd_Ready, seq[i % 7] == "U");
            chk("starve_done", bus.o_Upd_Done, (i % 7) == 6);
        end
        @(negedge clk); drive(0, 8'h00, 0, 8'h00, 4'd0, 10'h000); #1;
        chk("write_count_5", we_cnt, 5);

        // reset during UPD_WAIT with a search valid in flight
        @(negedge clk); drive(1, 8'h05, 0, 8'h00, 4'd0, 10'h000); #1;
        chk("abort_srch", bus.o_Srch_Ready, 1);
        @(negedge clk); drive(0, 8'h00, 1, 8'h50, 4'd1, 10'h155); #1;
        chk("abort_upd", bus.o_Upd_Ready, 1);
        @(negedge clk); drive(1, 8'h05, 0, 8'h00, 4'd0, 10'h000); rst = 1'b1; #1;
        chk("abort_vvalid", bus.o_Srch_Vect_Valid, 0);
        chk("abort_srch_ready", bus.o_Srch_Ready, 0);
        chk("abort_mem_en", bus.o_Mem_En, 0);
        chk("abort_mem_we", bus.o_Mem_We, 0);
        chk("abort_addr", bus.o_Mem_Addr, 0);
        chk("abort_wdata", bus.o_Mem_Wdata, 0);
        chk("abort_vect", bus.o_Srch_Vect, 0);
        chk("abort_done", bus.o_Upd_Done, 0);
        @(negedge clk); rst = 1'b0; drive(0, 8'h00, 0, 8'h00, 4'd0, 10'h000); #1;
        chk("rel_done_0", bus.o_Upd_Done, 0);
        chk("rel_we_0", bus.o_Mem_We, 0);
        @(negedge clk); #1;
        chk("rel_done_1", bus.o_Upd_Done, 0);
        chk("rel_we_1", bus.o_Mem_We, 0);
        chk("rel_vvalid_1", bus.o_Srch_Vect_Valid, 0);
        @(negedge clk); #1;
        chk("rel_err", bus.o_Upd_Err, 0);
        chk("rel_write_count", we_cnt, 5);
        chk("rel_mem_50", mem[8'h50], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
